// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdc_pkg
// Brief    : Shared types and constants for the toggle-handshake CDC blocks.
// Revision : 1.0 - initial release
// ============================================================================
package cdc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int MIN_SYNC_STAGES = 2;

endpackage
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
// Module   : sync_bit
// Brief    : N-flop single-bit synchroniser, synchronous active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= {r_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cdc_toggle_rx.sv
`default_nettype none
// ============================================================================
// Module   : cdc_toggle_rx
// Brief    : Destination side of the toggle CDC handshake; valid/ready out.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_toggle_rx
  import cdc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack_tgl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              proto_err
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
    $error("cdc_toggle_rx: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
  end

  state_e              r_state;
  logic                r_req_seen;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_ack_tgl;
  logic                r_busy;
  logic                r_proto_err;

  state_e              w_state_nxt;
  logic                w_req_seen_nxt;
  logic                w_out_valid_nxt;
  logic [DATA_W-1:0]   w_out_data_nxt;
  logic                w_ack_tgl_nxt;
  logic                w_proto_err_nxt;
  logic                w_req_s;
  logic                w_req_pend;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_sync_req (
    .clk (clk),
    .rst (rst),
    .i_d (req_tgl),
    .o_q (w_req_s)
  );

  assign w_req_pend = w_req_s ^ r_req_seen;

  always_comb begin
    w_state_nxt     = r_state;
    w_req_seen_nxt  = r_req_seen;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_ack_tgl_nxt   = r_ack_tgl;
    w_proto_err_nxt = r_proto_err;
    case (r_state)
      IDLE: begin
        // req_data is sampled raw: the source holds it stable until ack flips
        if (w_req_pend) begin
          w_out_data_nxt  = req_data;
          w_req_seen_nxt  = w_req_s;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = HOLD;
        end
      end
      HOLD: begin
        // A second flip stays pending and is captured after acceptance
        if (w_req_pend) begin
          w_proto_err_nxt = 1'b1;
        end
        if (r_out_valid && out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_ack_tgl_nxt   = ~r_ack_tgl;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req_seen  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_ack_tgl   <= 1'b0;
      r_busy      <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_seen  <= w_req_seen_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_ack_tgl   <= w_ack_tgl_nxt;
      r_busy      <= (w_state_nxt == HOLD);
      r_proto_err <= w_proto_err_nxt;
    end
  end

  assign ack_tgl   = r_ack_tgl;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign proto_err = r_proto_err;

endmodule
`default_nettype wire
